// File: rtl/switch_digit_entry.sv
// Debounced one-hot switch bank to digit entry buffer with valid/ready code hand-off.
// Each accepted press shifts in one nibble. A full or entered buffer commits to code.
module switch_digit_entry #(
  parameter int unsigned NUM_SW      = 16,
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned DEBOUNCE    = 50,
  parameter bit          AUTO_COMMIT = 1'b1,
  parameter int unsigned ENTER_SW    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_SW-1:0]     sw,
  output logic [4*DIGITS-1:0]   digits,
  output logic [3:0]            count,
  output logic                  err,
  output logic [4*DIGITS-1:0]   code,
  output logic                  code_valid,
  input  logic                  code_ready
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(DEBOUNCE + 1);
  localparam logic [3:0]  Full = 4'(DIGITS);

  typedef enum logic [1:0] {StIdle, StHeld, StBlocked} state_e;

  logic [NUM_SW-1:0] sync1_q, sync2_q, cand_q, stable_q;
  logic [CntW-1:0]   cnt_q;
  state_e            state_q, state_d;
  logic [W-1:0]      digits_q, digits_d, code_q, code_d;
  logic [3:0]        count_q, count_d;
  logic              err_q, err_d, valid_q, valid_d;

  // cand_q tracks the synchronised pattern; it is promoted once it survives DEBOUNCE edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
      if (sync2_q != cand_q) begin
        cand_q <= sync2_q;
        cnt_q  <= CntW'(1);
      end else if (cnt_q < CntW'(DEBOUNCE - 1)) begin
        cnt_q <= cnt_q + CntW'(1);
      end else if (cnt_q == CntW'(DEBOUNCE - 1)) begin
        stable_q <= cand_q;
        cnt_q    <= CntW'(DEBOUNCE);
      end
    end
  end

  logic [3:0]   idx;
  logic         press, reject, commit_blocked, is_enter;
  logic [W-1:0] shifted;

  always_comb begin
    idx = 4'd0;
    for (int i = 0; i < NUM_SW; i++) begin
      if (stable_q[i]) idx = 4'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    count_d  = count_q;
    code_d   = code_q;
    valid_d  = valid_q;
    err_d    = 1'b0;
    press    = 1'b0;
    reject   = 1'b0;
    is_enter = (AUTO_COMMIT == 1'b0) && (32'(idx) == ENTER_SW);
    shifted  = W'(digits_q << 4) | W'(idx);
    commit_blocked = valid_q && !code_ready;

    if (valid_q && code_ready) valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (stable_q != '0) begin
          if ($onehot(stable_q)) begin
            state_d = StHeld;
            press   = 1'b1;
          end else begin
            state_d = StBlocked;
            reject  = 1'b1;
          end
        end
      end
      StHeld, StBlocked: begin
        if (stable_q == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (reject) err_d = 1'b1;

    if (press) begin
      if (AUTO_COMMIT) begin
        if (count_q == Full - 4'd1) begin
          if (commit_blocked) begin
            err_d = 1'b1;
          end else begin
            code_d   = shifted;
            valid_d  = 1'b1;
            digits_d = '0;
            count_d  = 4'd0;
          end
        end else begin
          digits_d = shifted;
          count_d  = count_q + 4'd1;
        end
      end else if (is_enter) begin
        if (count_q != 4'd0) begin
          if (commit_blocked) begin
            err_d = 1'b1;
          end else begin
            code_d   = digits_q;
            valid_d  = 1'b1;
            digits_d = '0;
            count_d  = 4'd0;
          end
        end
      end else begin
        // Window mode: the oldest digit falls out once the buffer is full.
        digits_d = shifted;
        count_d  = (count_q == Full) ? count_q : count_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      digits_q <= '0;
      count_q  <= 4'd0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      count_q  <= count_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign digits     = digits_q;
  assign count      = count_q;
  assign err        = err_q;
  assign code       = code_q;
  assign code_valid = valid_q;

endmodule
